// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the phase-gated pipeline stages.
package cpu_pkg;

  // Instruction-cycle timing, expressed in clock phases.
  localparam int unsigned PHASES        = 10;
  localparam int unsigned PHASE_W       = 4;
  localparam int unsigned UPDATE_PHASE  = 9;
  localparam int unsigned FETCH_PHASE   = 0;
  localparam int unsigned TIMEOUT_PHASE = 7;

  // Instruction-fetch handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_stage_phase_counter.sv
// Free-running modulo-PHASES counter that sequences one instruction cycle.
module phase_counter #(
  parameter int unsigned PHASES = 10,
  parameter int unsigned WIDTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] phase
);

  localparam logic [WIDTH-1:0] LAST_PHASE = WIDTH'(PHASES - 1);

  // Advance once per clock, wrapping after the last phase.
  // NOTE: reset is synchronous, so it is tested inside the clocked branch only.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= '0;
    end else if (phase == LAST_PHASE) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and instruction-fetch stage: registers next_pc once per
// instruction cycle and fetches the word at pc over a req/ack handshake.
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned PHASES        = cpu_pkg::PHASES,
  parameter int unsigned UPDATE_PHASE  = cpu_pkg::UPDATE_PHASE,
  parameter int unsigned FETCH_PHASE   = cpu_pkg::FETCH_PHASE,
  parameter int unsigned TIMEOUT_PHASE = cpu_pkg::TIMEOUT_PHASE
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  next_pc,
  input  logic         halt,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic         fetch_error,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [PHASE_W-1:0] UPD_P = PHASE_W'(UPDATE_PHASE);
  localparam logic [PHASE_W-1:0] FET_P = PHASE_W'(FETCH_PHASE);
  localparam logic [PHASE_W-1:0] TMO_P = PHASE_W'(TIMEOUT_PHASE);

  fetch_state_t state, state_next;
  logic         start_fetch;
  logic         accept;
  logic         timeout;
  logic         at_update;
  logic         at_fetch;
  logic         at_timeout;
  logic         in_window;
  logic         misaligned;

  phase_counter #(
    .PHASES (PHASES),
    .WIDTH  (PHASE_W)
  ) u_phase_counter (
    .clock (clock),
    .reset (reset),
    .phase (phase)
  );

  assign at_update  = (phase == UPD_P);
  assign at_fetch   = (phase == FET_P);
  assign at_timeout = (phase == TMO_P);
  assign in_window  = (phase <= TMO_P);
  assign misaligned = (next_pc[1:0] != 2'b00);

  // The address bus simply mirrors pc; it is only meaningful while imem_req=1.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Fetch FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the single-cycle control strobes it raises.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    start_fetch = 1'b0;
    accept      = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      IDLE: begin
        if (at_fetch && !halt && !fetch_error) begin
          state_next  = REQ;
          start_fetch = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack && in_window) begin
          state_next = DONE;
          accept     = 1'b1;
        end else if (at_timeout) begin
          state_next = ERR;
          timeout    = 1'b1;
        end
      end
      DONE: begin
        if (at_update) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // PC register, request line, instruction register and sticky fault.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      if (start_fetch) begin
        imem_req    <= 1'b1;
        instr_valid <= 1'b0;
      end
      if (accept) begin
        imem_req    <= 1'b0;
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (timeout) begin
        imem_req    <= 1'b0;
        fetch_error <= 1'b1;
      end
      if (at_update) begin
        if (misaligned) begin
          fetch_error <= 1'b1;
        end else if (!halt && !fetch_error) begin
          pc <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed per-cycle vector table,
// hand sequences for reset/timeout corners, then randomized cycles.
module tb_pc_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int NO_ACK = 10;
  localparam int NO_RST = 10;

  logic        clock;
  logic        reset;
  logic [31:0] next_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_error;
  logic [3:0]  phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-cycle level reference model.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_err;

  pc_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .next_pc     (next_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_error (fetch_error),
    .phase       (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_pc",    pc, RESET_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_err",   32'(fetch_error), 32'd0);
  endtask

  // Drives one 10-clock instruction cycle starting at phase 0 and checks every
  // phase against the model. ack is pulsed in phase a (NO_ACK = none). If
  // rst_at < NO_RST, reset is asserted in that phase and the cycle is cut short.
  task automatic run_cycle(input logic [31:0] np, input int a, input logic [31:0] rd,
                           input logic h0, input logic h9, input int rst_at);
    logic        fetch, acc, tmo, exp_req, exp_valid, exp_err, err_now, rst_hit;
    logic [31:0] exp_instr;
    fetch   = !h0 && !m_err;
    acc     = fetch && (a >= 1) && (a <= 7);
    tmo     = fetch && !acc;
    rst_hit = 1'b0;
    for (int p = 0; p < 10; p++) begin
      @(negedge clock);
      exp_req   = fetch && (p >= 1) && (p <= (acc ? a : 7));
      exp_valid = (p == 0 || !fetch) ? m_valid : (acc && p > a);
      exp_instr = (acc && p > a) ? rd : m_instr;
      exp_err   = m_err || (tmo && p >= 8);
      check("phase",       32'(phase), 32'(p));
      check("pc",          pc, m_pc);
      check("pc_plus4",    pc_plus4, m_pc + 32'd4);
      check("imem_req",    32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", 32'(instr_valid), 32'(exp_valid));
      check("instr",       instr, exp_instr);
      check("fetch_error", 32'(fetch_error), 32'(exp_err));
      reset      = 1'b0;
      next_pc    = np;
      halt       = (p == 0) ? h0 : ((p == 9) ? h9 : 1'b0);
      imem_ack   = (p == a);
      imem_rdata = (p == a) ? rd : $urandom;
      if (p == rst_at) begin
        reset   = 1'b1;
        rst_hit = 1'b1;
        break;
      end
    end
    if (rst_hit) begin
      @(negedge clock);
      check_reset();
      // A late response arriving during reset must be discarded.
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      model_reset();
    end else begin
      err_now = m_err || tmo;
      if (np[1:0] != 2'b00) m_err = 1'b1;
      else if (!h9 && !err_now) m_pc = np;
      m_err = m_err || tmo;
      if (acc) begin
        m_instr = rd;
        m_valid = 1'b1;
      end else if (fetch) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    imem_ack = 1'b0;
    halt     = 1'b0;
    @(negedge clock);
    check_reset();
    model_reset();
  endtask

  typedef struct {
    logic [31:0] np;
    int          a;
    logic [31:0] rd;
    logic        h0;
    logic        h9;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] np;
    reset      = 1'b1;
    next_pc    = 32'h0;
    halt       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    model_reset();

    //          next_pc        ack rdata          h0    h9    pc after       instr          valid err
    vecs[0] = '{32'h0000_0004, 2,  32'h2008_0005, 1'b0, 1'b0, 32'h0000_0004, 32'h2008_0005, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0008, 1,  32'h1111_1111, 1'b0, 1'b0, 32'h0000_0008, 32'h1111_1111, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_000C, 1,  32'h2222_2222, 1'b0, 1'b0, 32'h0000_000C, 32'h2222_2222, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0010, 1,  32'h3333_3333, 1'b0, 1'b0, 32'h0000_0010, 32'h3333_3333, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0014, 3,  32'h4444_4444, 1'b1, 1'b1, 32'h0000_0010, 32'h3333_3333, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0014, 7,  32'h5555_5555, 1'b0, 1'b0, 32'h0000_0014, 32'h5555_5555, 1'b1, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 1,  32'h6666_6666, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h6666_6666, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0000, 1,  32'h7777_7777, 1'b0, 1'b0, 32'h0000_0000, 32'h7777_7777, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_0006, 1,  32'h8888_8888, 1'b0, 1'b0, 32'h0000_0000, 32'h8888_8888, 1'b1, 1'b1};
    vecs[9] = '{32'h0000_0004, 1,  32'h9999_9999, 1'b0, 1'b0, 32'h0000_0000, 32'h8888_8888, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_cycle(vecs[i].np, vecs[i].a, vecs[i].rd, vecs[i].h0, vecs[i].h9, NO_RST);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_pc", i),    pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err", i),   32'(fetch_error), 32'(vecs[i].exp_err));
      if (i == 6) check("wrap_pc_plus4", pc_plus4, 32'h0);
    end

    // Fetch timeout, then two frozen cycles (20 clocks), then reset clears it.
    do_reset();
    run_cycle(32'h0000_0004, NO_ACK, 32'h0, 1'b0, 1'b0, NO_RST);
    run_cycle(32'h0000_0008, 1, 32'hABCD_0001, 1'b0, 1'b0, NO_RST);
    run_cycle(32'h0000_000C, 1, 32'hABCD_0002, 1'b0, 1'b0, NO_RST);
    check("timeout_pc_frozen", m_pc, RESET_PC);
    do_reset();

    // Reset in phase 3 while a request is outstanding; the next fetch must
    // deliver its own word, not the late one.
    run_cycle(32'h0000_0004, 5, 32'h0BAD_0BAD, 1'b0, 1'b0, 3);
    run_cycle(32'h0000_0004, 3, 32'h1234_5678, 1'b0, 1'b0, NO_RST);
    @(posedge clock);
    #1;
    check("post_rst_instr", instr, 32'h1234_5678);
    check("post_rst_pc",    pc, 32'h0000_0004);

    // Randomized instruction cycles.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 15) == 0)
        np = $urandom | 32'h1;
      else if ($urandom_range(0, 1) == 0)
        np = m_pc + 32'd4;
      else
        np = $urandom & 32'hFFFF_FFFC;
      run_cycle(np, $urandom_range(0, 10), $urandom,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : NO_RST);
      if (m_err && $urandom_range(0, 2) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
